// File: rtl/seg7_pair_decoder.sv
// Decodes a stable two-digit active-low 7-segment pattern back to 0..15 (or flags it illegal).
// Latency: a new pattern held from before edge 1 is presented after edge STABLE_CYCLES.
// Backpressure: one result pending; a result accepted while out_ready=0 is dropped and sets sticky out_ovf.
module seg7_pair_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] seg_n,
    output logic [3:0]  out_value,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_ovf,
    input  logic        ovf_clr
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_PRE = 8'(STABLE_CYCLES - 2);

    typedef enum logic {IDLE, PEND} state_t;

    state_t      state;
    logic [13:0] r;
    logic        r_vld;
    logic [7:0]  cnt;
    logic [13:0] last_pat;
    logic        have_last;

    logic        match;
    logic        accept;
    logic [6:0]  p_tens;
    logic [6:0]  p_ones;
    logic [3:0]  ones_val;
    logic        ones_ok;
    logic        tens_ok;
    logic        tens_one;
    logic        dec_err;
    logic [3:0]  dec_value;

    // r_vld keeps the first post-reset sample from matching the cleared register,
    // so every pattern needs the full STABLE_CYCLES edges regardless of its value.
    assign match  = r_vld && (seg_n == r);
    assign accept = match && (cnt == CNT_PRE) && (!have_last || (r != last_pat));

    assign p_tens = ~r[13:7];
    assign p_ones = ~r[6:0];

    always_comb begin
        ones_val = 4'd0;
        ones_ok  = 1'b1;
        case (p_ones)
            7'h3F:   ones_val = 4'd0;
            7'h06:   ones_val = 4'd1;
            7'h5B:   ones_val = 4'd2;
            7'h4F:   ones_val = 4'd3;
            7'h66:   ones_val = 4'd4;
            7'h6D:   ones_val = 4'd5;
            7'h7D:   ones_val = 4'd6;
            7'h07:   ones_val = 4'd7;
            7'h7F:   ones_val = 4'd8;
            7'h6F:   ones_val = 4'd9;
            default: ones_ok  = 1'b0;
        endcase
    end

    always_comb begin
        tens_ok  = 1'b1;
        tens_one = 1'b0;
        case (p_tens)
            7'h00:   tens_one = 1'b0;
            7'h06:   tens_one = 1'b1;
            default: tens_ok  = 1'b0;
        endcase
    end

    always_comb begin
        dec_err   = !(ones_ok && tens_ok && (!tens_one || (ones_val <= 4'd5)));
        dec_value = 4'd0;
        if (!dec_err)
            dec_value = tens_one ? (ones_val + 4'd10) : ones_val;
    end

    // Stability filter: sample register plus saturating match counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r         <= '0;
            r_vld     <= 1'b0;
            cnt       <= '0;
            last_pat  <= '0;
            have_last <= 1'b0;
        end else begin
            r     <= seg_n;
            r_vld <= 1'b1;
            if (!match)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 8'd1;
            if (accept) begin
                last_pat  <= r;
                have_last <= 1'b1;
            end
        end
    end

    // Handshake FSM; out_valid is the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_value <= 4'd0;
            out_err   <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_value <= dec_value;
                        out_err   <= dec_err;
                        state     <= PEND;
                    end
                end
                PEND: begin
                    if (accept && out_ready) begin
                        out_value <= dec_value;
                        out_err   <= dec_err;
                    end else if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept && (state == PEND) && !out_ready)
                out_ovf <= 1'b1;
            else if (ovf_clr)
                out_ovf <= 1'b0;
        end
    end

    assign out_valid = (state == PEND);

endmodule

// File: tb/tb_seg7_pair_decoder.sv
// Bench for seg7_pair_decoder: vector table with a result scoreboard, plus hand-written timing sequences.
module tb_seg7_pair_decoder;

    logic        clk;
    logic        rst_n;
    logic [13:0] seg_n;
    logic [3:0]  out_value;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
    logic        out_ovf;
    logic        ovf_clr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [13:0] seg;
        logic [3:0]  val;
        logic        err;
    } vec_t;

    typedef struct {
        logic [3:0] val;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[19];

    seg7_pair_decoder #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_n     (seg_n),
        .out_value (out_value),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ovf   (out_ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ones_pat(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            default: return 7'h6F;
        endcase
    endfunction

    // Active-low two-digit encoding of v (0..15).
    function automatic logic [13:0] enc(input int v);
        logic [6:0] t;
        t = (v >= 10) ? 7'h06 : 7'h00;
        return ~{t, ones_pat(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard: a handshake happens at the next edge when valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual value=%0d err=%0b required no result",
                         out_value, out_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_value", 32'(out_value), 32'(e.val));
                chk("sb_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int v = 0; v < 16; v++) vecs[v] = '{enc(v), 4'(v), 1'b0};
        vecs[0]  = '{14'h3FC0, 4'd0, 1'b0};
        vecs[7]  = '{14'h3FF8, 4'd7, 1'b0};
        vecs[13] = '{14'h3CB0, 4'd13, 1'b0};
        vecs[16] = '{14'h3FFF, 4'd0, 1'b1};  // all segments off
        vecs[17] = '{14'h3CF8, 4'd0, 1'b1};  // tens "1" with ones "7"
        vecs[18] = '{14'h0000, 4'd0, 1'b1};  // all segments on

        rst_n     = 1'b0;
        seg_n     = 14'h3FFF;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        #23;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_value", 32'(out_value), 0);
        chk("rst_err", 32'(out_err), 0);
        chk("rst_ovf", 32'(out_ovf), 0);

        // Test 1: first-result latency and no re-emission while held.
        @(posedge clk); #1;
        rst_n = 1'b1;
        seg_n = 14'h3FF8;
        exp_q.push_back('{4'd7, 1'b0});
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            chk("t1_latency", 32'(out_valid), 32'(i == 4));
        end
        chk("t1_value", 32'(out_value), 7);
        chk("t1_err", 32'(out_err), 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t1_consumed", 32'(out_valid), 0);
        repeat (6) @(posedge clk);
        #1;
        chk("t1_held_quiet", 32'(out_valid), 0);
        chk("t1_drain", 32'(exp_q.size()), 0);

        // Tests 2 and 3: sweep the vector table with ready held high.
        for (int k = 0; k < 19; k++) begin
            exp_q.push_back('{vecs[k].val, vecs[k].err});
            seg_n = vecs[k].seg;
            repeat (6) @(posedge clk);
            #1;
            chk("sweep_drain", 32'(exp_q.size()), 0);
        end

        // Test 4: glitch restarts the count; result 4 edges after the glitch ends.
        exp_q.push_back('{4'd9, 1'b0});
        seg_n = enc(9);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            chk("t4_pre_glitch", 32'(out_valid), 0);
        end
        seg_n = enc(1);
        @(posedge clk); #1;
        chk("t4_glitch", 32'(out_valid), 0);
        seg_n = enc(9);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            chk("t4_latency", 32'(out_valid), 32'(i == 4));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("t4_drain", 32'(exp_q.size()), 0);
        // Returning to the last accepted pattern yields nothing.
        seg_n = enc(1);
        @(posedge clk); #1;
        seg_n = enc(9);
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            chk("t4_return_quiet", 32'(out_valid), 0);
        end

        // Test 5: drop with ready low, sticky overflow, clear, set-dominates-clear.
        out_ready = 1'b0;
        seg_n = 14'h3FA4;
        repeat (6) @(posedge clk);
        #1;
        chk("t5_valid", 32'(out_valid), 1);
        chk("t5_first", 32'(out_value), 2);
        seg_n = 14'h3FF8;
        repeat (6) @(posedge clk);
        #1;
        chk("t5_hold_value", 32'(out_value), 2);
        chk("t5_ovf_set", 32'(out_ovf), 1);
        chk("t5_still_valid", 32'(out_valid), 1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("t5_ovf_clr", 32'(out_ovf), 0);
        seg_n = enc(3);
        repeat (3) @(posedge clk);
        #1;
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("t5_set_dominates", 32'(out_ovf), 1);
        chk("t5_value_kept", 32'(out_value), 2);
        exp_q.push_back('{4'd2, 1'b0});
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_drained", 32'(out_valid), 0);
        chk("t5_ovf_sticky", 32'(out_ovf), 1);
        chk("t5_drain", 32'(exp_q.size()), 0);

        // Test 6: async reset while pending, then re-accept of the held pattern.
        out_ready = 1'b0;
        seg_n = enc(12);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_pend", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(out_valid), 0);
        chk("t6_async_value", 32'(out_value), 0);
        chk("t6_async_ovf", 32'(out_ovf), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            chk("t6_reaccept", 32'(out_valid), 32'(i == 4));
        end
        chk("t6_value", 32'(out_value), 12);
        exp_q.push_back('{4'd12, 1'b0});
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_done", 32'(out_valid), 0);
        chk("t6_drain", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
